// File: rtl/time_set_ctrl.sv
// time_set_ctrl: debounced HH:MM edit session for the digital clock.
// Produces the edited BCD time, a one-cycle load strobe and per-digit blink masks.
module time_set_ctrl #(
    parameter logic [15:0] DB_CYCLES = 16'd50000,
    parameter logic [23:0] BLINK_DIV = 24'd6000000
) (
    input  logic       pCLK,
    input  logic       pRST,
    input  logic [3:0] TSW,
    input  logic [3:0] CUR_H1,
    input  logic [3:0] CUR_H0,
    input  logic [3:0] CUR_M1,
    input  logic [3:0] CUR_M0,
    output logic [3:0] SET_H1,
    output logic [3:0] SET_H0,
    output logic [3:0] SET_M1,
    output logic [3:0] SET_M0,
    output logic       LOAD,
    output logic       EDIT,
    output logic [3:0] BLANK
);
    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] EDIT_HR  = 2'd1;
    localparam logic [1:0] EDIT_MIN = 2'd2;
    localparam logic [1:0] COMMIT   = 2'd3;

    // Button levels are kept in pressed=1 polarity from the first sync stage on.
    logic [3:0]       s1_q, s1_d, s2_q, s2_d, db_q, db_d, dbd_q, dbd_d, ev_q, ev_d;
    logic [3:0][15:0] cnt_q, cnt_d;
    logic [1:0]       state_q, state_d;
    logic [7:0]       hr_q, hr_d, mn_q, mn_d;
    logic [23:0]      bcnt_q, bcnt_d;
    logic             boff_q, boff_d;

    logic       cancel, ok, mode, up, down, edit_now, restart, bexp, hr_ok, mn_ok;
    logic [7:0] cur_hr, cur_mn, hr_inc, hr_dec, mn_inc, mn_dec;

    always_comb begin
        s1_d = ~TSW;
        s2_d = s1_q;
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = (s2_q[i] == db_q[i] || cnt_q[i] == DB_CYCLES - 16'd1) ? 16'd0 : cnt_q[i] + 16'd1;
            db_d[i]  = (s2_q[i] != db_q[i] && cnt_q[i] == DB_CYCLES - 16'd1) ? s2_q[i] : db_q[i];
        end
        dbd_d = db_q;
        ev_d  = db_q & ~dbd_q;
    end

    // dbd_q is the debounced level aligned with ev_q, so OK fires on the later press.
    always_comb begin
        cancel = ev_q[3];
        ok     = (ev_q[0] | ev_q[1]) & dbd_q[0] & dbd_q[1] & ~cancel;
        mode   = ev_q[0] & ~ok & ~cancel;
        up     = ev_q[1] & ~ev_q[2] & ~ok & ~mode & ~cancel;
        down   = ev_q[2] & ~ev_q[1] & ~ok & ~mode & ~cancel;
    end

    always_comb begin
        cur_hr = {CUR_H1, CUR_H0};
        cur_mn = {CUR_M1, CUR_M0};
        hr_ok  = CUR_H0 <= 4'd9 && cur_hr <= 8'h23;
        mn_ok  = CUR_M1 <= 4'd5 && CUR_M0 <= 4'd9;
        hr_inc = hr_q == 8'h23 ? 8'h00 : hr_q[3:0] == 4'd9 ? {hr_q[7:4] + 4'd1, 4'd0} : hr_q + 8'd1;
        hr_dec = hr_q == 8'h00 ? 8'h23 : hr_q[3:0] == 4'd0 ? {hr_q[7:4] - 4'd1, 4'd9} : hr_q - 8'd1;
        mn_inc = mn_q == 8'h59 ? 8'h00 : mn_q[3:0] == 4'd9 ? {mn_q[7:4] + 4'd1, 4'd0} : mn_q + 8'd1;
        mn_dec = mn_q == 8'h00 ? 8'h59 : mn_q[3:0] == 4'd0 ? {mn_q[7:4] - 4'd1, 4'd9} : mn_q - 8'd1;
    end

    always_comb begin
        state_d  = state_q;
        hr_d     = hr_q;
        mn_d     = mn_q;
        edit_now = state_q == EDIT_HR || state_q == EDIT_MIN;
        restart  = (state_q == IDLE && mode) || (edit_now && (up || down));
        if (state_q == IDLE) begin
            if (mode) begin
                state_d = EDIT_HR;
                hr_d    = hr_ok ? cur_hr : 8'h00;
                mn_d    = mn_ok ? cur_mn : 8'h00;
            end
        end else if (state_q == COMMIT) begin
            state_d = IDLE;
        end else if (cancel) begin
            state_d = IDLE;
        end else if (ok) begin
            state_d = COMMIT;
        end else if (mode) begin
            state_d = state_q == EDIT_HR ? EDIT_MIN : EDIT_HR;
        end else if (state_q == EDIT_HR) begin
            hr_d = up ? hr_inc : down ? hr_dec : hr_q;
        end else begin
            mn_d = up ? mn_inc : down ? mn_dec : mn_q;
        end
        bexp   = bcnt_q == BLINK_DIV - 24'd1;
        bcnt_d = (restart || state_q == IDLE || bexp) ? 24'd0 : bcnt_q + 24'd1;
        boff_d = (restart || state_q == IDLE) ? 1'b0 : bexp ? ~boff_q : boff_q;
    end

    always_ff @(posedge pCLK or posedge pRST) begin
        if (pRST) begin
            s1_q    <= '0;
            s2_q    <= '0;
            db_q    <= '0;
            dbd_q   <= '0;
            ev_q    <= '0;
            cnt_q   <= '0;
            state_q <= IDLE;
            hr_q    <= '0;
            mn_q    <= '0;
            bcnt_q  <= '0;
            boff_q  <= 1'b0;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            db_q    <= db_d;
            dbd_q   <= dbd_d;
            ev_q    <= ev_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            hr_q    <= hr_d;
            mn_q    <= mn_d;
            bcnt_q  <= bcnt_d;
            boff_q  <= boff_d;
        end
    end

    assign {SET_H1, SET_H0} = hr_q;
    assign {SET_M1, SET_M0} = mn_q;
    assign LOAD  = state_q == COMMIT;
    assign EDIT  = state_q != IDLE;
    assign BLANK = !boff_q ? 4'b0000 : state_q == EDIT_HR ? 4'b1100 : state_q == EDIT_MIN ? 4'b0011 : 4'b0000;
endmodule

// File: tb/tb_time_set_ctrl.sv
// tb_time_set_ctrl: directed and randomized button sessions checked against
// an integer hour/minute model with timing derived from the debounce latency.
module tb_time_set_ctrl;
    localparam int DB  = 4;
    localparam int BD  = 8;
    localparam int LAT = DB + 4;

    logic       pCLK = 1'b0;
    logic       pRST = 1'b1;
    logic [3:0] TSW = 4'hF;
    logic [3:0] CUR_H1 = '0, CUR_H0 = '0, CUR_M1 = '0, CUR_M0 = '0;
    logic [3:0] SET_H1, SET_H0, SET_M1, SET_M0, BLANK;
    logic       LOAD, EDIT;

    int vectors = 0, errs = 0, cyc = 0, load_cnt = 0, load_exp = 0;
    int st = 0, hour = 0, minute = 0, rst_cyc = 0;
    logic [3:0] opts [7] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'h6, 4'h5};

    time_set_ctrl #(.DB_CYCLES(16'(DB)), .BLINK_DIV(24'(BD))) dut (
        .pCLK(pCLK), .pRST(pRST), .TSW(TSW),
        .CUR_H1(CUR_H1), .CUR_H0(CUR_H0), .CUR_M1(CUR_M1), .CUR_M0(CUR_M0),
        .SET_H1(SET_H1), .SET_H0(SET_H0), .SET_M1(SET_M1), .SET_M0(SET_M0),
        .LOAD(LOAD), .EDIT(EDIT), .BLANK(BLANK)
    );

    always #5 pCLK = ~pCLK;

    always @(posedge pCLK) begin
        cyc <= cyc + 1;
        if (LOAD) load_cnt <= load_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int blank_exp();
        if ((st == 1 || st == 2) && ((cyc - rst_cyc) / BD) % 2 == 1) return st == 1 ? 12 : 3;
        return 0;
    endfunction

    task automatic check_all(input string tag);
        chk({tag, "_hour"}, {SET_H1, SET_H0}, 32'(((hour / 10) << 4) | (hour % 10)));
        chk({tag, "_min"}, {SET_M1, SET_M0}, 32'(((minute / 10) << 4) | (minute % 10)));
        chk({tag, "_load"}, LOAD, 32'(st == 3));
        chk({tag, "_edit"}, EDIT, 32'(st != 0));
        chk({tag, "_blank"}, BLANK, 32'(blank_exp()));
    endtask

    task automatic apply(input logic [3:0] b);
        int h;
        if (st == 0) begin
            if (b[0] && !b[1] && !b[3]) begin
                h = CUR_H1 * 10 + CUR_H0;
                hour = (CUR_H0 <= 9 && h <= 23) ? h : 0;
                minute = (CUR_M1 <= 5 && CUR_M0 <= 9) ? CUR_M1 * 10 + CUR_M0 : 0;
                st = 1;
                rst_cyc = cyc;
            end
        end else if (b[3]) begin
            st = 0;
        end else if (b[0] && b[1]) begin
            st = 3;
            load_exp++;
        end else if (b[0]) begin
            st = 3 - st;
        end else if (b[1] ^ b[2]) begin
            if (st == 1) hour = (hour + (b[1] ? 1 : 23)) % 24;
            else minute = (minute + (b[1] ? 1 : 59)) % 60;
            rst_cyc = cyc;
        end
    endtask

    task automatic release_wait();
        TSW = 4'hF;
        repeat (DB + 8) @(negedge pCLK);
        check_all("released");
    endtask

    task automatic press(input logic [3:0] b);
        @(negedge pCLK);
        TSW = ~b;
        repeat (LAT - 1) @(negedge pCLK);
        chk("pre_edit", EDIT, 32'(st != 0));
        chk("pre_load", LOAD, 0);
        @(negedge pCLK);
        apply(b);
        check_all("post");
        if (st == 3) begin
            @(negedge pCLK);
            st = 0;
            check_all("commit_end");
        end
        release_wait();
    endtask

    task automatic set_cur(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
        {CUR_H1, CUR_H0, CUR_M1, CUR_M0} = {a, b, c, d};
    endtask

    initial begin
        repeat (3) @(negedge pCLK);
        check_all("reset");
        pRST = 1'b0;
        repeat (3) @(negedge pCLK);

        set_cur(4'd1, 4'd2, 4'd3, 4'd4);
        for (int i = 0; i < 10; i++) begin
            TSW[0] = 1'(i % 2);
            repeat (2) @(negedge pCLK);
        end
        TSW[0] = 1'b0;
        repeat (LAT - 1) @(negedge pCLK);
        chk("bounce_early", EDIT, 0);
        @(negedge pCLK);
        apply(4'h1);
        check_all("bounce");
        release_wait();
        press(4'h2);
        press(4'h8);

        set_cur(4'd2, 4'd3, 4'd4, 4'd5);
        press(4'h1);
        press(4'h2);
        press(4'h4);
        press(4'h8);

        set_cur(4'd0, 4'd9, 4'd5, 4'd9);
        press(4'h1);
        press(4'h1);
        press(4'h2);
        press(4'h3);

        press(4'h1);
        repeat (3) press(4'h2);
        press(4'h8);

        press(4'h1);
        repeat (40) begin
            @(negedge pCLK);
            chk("blink", BLANK, 32'(blank_exp()));
        end
        press(4'h2);
        repeat (20) begin
            @(negedge pCLK);
            chk("blink_restart", BLANK, 32'(blank_exp()));
        end
        press(4'h8);

        press(4'h1);
        press(4'h1);
        @(negedge pCLK);
        pRST = 1'b1;
        #1;
        st = 0;
        hour = 0;
        minute = 0;
        check_all("midreset");
        repeat (2) @(negedge pCLK);
        pRST = 1'b0;
        repeat (2) @(negedge pCLK);
        check_all("after_reset");
        press(4'h2);

        for (int n = 0; n < 40; n++) begin
            set_cur(4'($urandom_range(0, 3)), 4'($urandom_range(0, 11)),
                    4'($urandom_range(0, 6)), 4'($urandom_range(0, 10)));
            press(opts[$urandom_range(0, 6)]);
        end

        chk("load_count", load_cnt, load_exp);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
